// File: rtl/pawn_push_enumerator_if.sv
// Move-record stream between the pawn push enumerator and the move-list buffer.
// master: drives valid + record fields, samples ready. slave: the reverse.
interface pawn_push_enumerator_if #(
  parameter int SQ_W = 6
) ();

  logic            move_valid;
  logic            move_ready;
  logic [SQ_W-1:0] move_from;
  logic [SQ_W-1:0] move_to;
  logic            move_double;
  logic            move_promo;

  modport master (
    output move_valid,
    output move_from,
    output move_to,
    output move_double,
    output move_promo,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_from,
    input  move_to,
    input  move_double,
    input  move_promo,
    output move_ready
  );

endinterface

// File: rtl/pawn_push_enumerator.sv
// Serialises every quiet pawn push (single and double) of one side into a
// valid/ready stream of move records, then pulses done with the move count.
// Ports: clk, reset (sync, active-high), start/side/occupied/pawns request,
// mv (master move stream), busy (emitting), done (1-cycle), move_count.
module pawn_push_enumerator #(
  parameter int FILES = 8,
  parameter int RANKS = 8,
  parameter int SQ_W  = $clog2(FILES*RANKS),
  parameter int CNT_W = $clog2(2*FILES+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   side,
  input  logic [FILES*RANKS-1:0] occupied,
  input  logic [FILES*RANKS-1:0] pawns,
  pawn_push_enumerator_if.master mv,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       move_count
);

  localparam int NSQ = FILES * RANKS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [NSQ-1:0]   pend_single_q;
  logic [NSQ-1:0]   pend_single_d;
  logic [NSQ-1:0]   pend_double_q;
  logic [NSQ-1:0]   pend_double_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             side_q;
  logic             side_d;

  // Per-side push masks straight from the request inputs.
  logic [NSQ-1:0] w_single;
  logic [NSQ-1:0] w_double;
  logic [NSQ-1:0] b_single;
  logic [NSQ-1:0] b_double;
  // Sources whose single push lands on the far rank.
  logic [NSQ-1:0] w_promo_m;
  logic [NSQ-1:0] b_promo_m;

  logic [NSQ-1:0] single_c;
  logic [NSQ-1:0] double_c;

  // Board edges are resolved at elaboration, so no square is ever
  // indexed off the board and no file wrap can occur (pushes are vertical).
  for (genvar s = 0; s < NSQ; s++) begin : g_sq
    localparam int R = s / FILES;

    if (R <= RANKS - 2) begin : g_ws
      assign w_single[s] = pawns[s] & ~occupied[s+FILES];
    end else begin : g_ws0
      assign w_single[s] = 1'b0;
    end

    if (R == 1) begin : g_wd
      assign w_double[s] = w_single[s]
                         & ~occupied[s+2*FILES];
    end else begin : g_wd0
      assign w_double[s] = 1'b0;
    end

    if (R >= 1) begin : g_bs
      assign b_single[s] = pawns[s] & ~occupied[s-FILES];
    end else begin : g_bs0
      assign b_single[s] = 1'b0;
    end

    if (R == RANKS - 2) begin : g_bd
      assign b_double[s] = b_single[s]
                         & ~occupied[s-2*FILES];
    end else begin : g_bd0
      assign b_double[s] = 1'b0;
    end

    assign w_promo_m[s] = (R == RANKS - 2);
    assign b_promo_m[s] = (R == 1);
  end

  assign single_c = side ? b_single : w_single;
  assign double_c = side ? b_double : w_double;

  logic start_any;
  assign start_any = (|single_c) | (|double_c);

  // Lowest pending source wins; a source's single push precedes its double.
  logic [NSQ-1:0]  pend_any;
  logic [NSQ-1:0]  sel_oh;
  logic [SQ_W-1:0] sel_idx;
  logic            sel_single;
  logic            sel_far;

  assign pend_any = pend_single_q | pend_double_q;

  always_comb begin
    sel_oh     = '0;
    sel_idx    = '0;
    sel_single = 1'b0;
    sel_far    = 1'b0;
    for (int i = NSQ - 1; i >= 0; i--) begin
      if (pend_any[i]) begin
        sel_oh     = '0;
        sel_oh[i]  = 1'b1;
        sel_idx    = SQ_W'(i);
        sel_single = pend_single_q[i];
        sel_far    = side_q ? b_promo_m[i]
                            : w_promo_m[i];
      end
    end
  end

  logic [SQ_W-1:0] step;
  logic [SQ_W-1:0] sel_to;

  assign step   = sel_single ? SQ_W'(FILES)
                             : SQ_W'(2 * FILES);
  assign sel_to = side_q ? (sel_idx - step)
                         : (sel_idx + step);

  logic hs;
  logic emit_last;

  assign hs = (state_q == S_EMIT) & mv.move_ready;

  // The handshake retires the final pending push.
  assign emit_last = ((pend_single_d | pend_double_d) == '0);

  // Pending masks, count and latched side.
  always_comb begin
    pend_single_d = pend_single_q;
    pend_double_d = pend_double_q;
    count_d       = count_q;
    side_d        = side_q;
    if (state_q == S_IDLE && start) begin
      pend_single_d = single_c;
      pend_double_d = double_c;
      count_d       = '0;
      side_d        = side;
    end else if (hs) begin
      count_d = count_q + 1'b1;
      if (sel_single) begin
        pend_single_d = pend_single_q & ~sel_oh;
      end else begin
        pend_double_d = pend_double_q & ~sel_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pend_single_q <= '0;
      pend_double_q <= '0;
      count_q       <= '0;
      side_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_single_q <= pend_single_d;
      pend_double_q <= pend_double_d;
      count_q       <= count_d;
      side_q        <= side_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = start_any ? S_EMIT : S_DONE;
        end
      end
      S_EMIT: begin
        if (hs && emit_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Record fields are gated to zero outside EMIT.
  always_comb begin
    mv.move_valid  = 1'b0;
    mv.move_from   = '0;
    mv.move_to     = '0;
    mv.move_double = 1'b0;
    mv.move_promo  = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      S_EMIT: begin
        mv.move_valid  = 1'b1;
        mv.move_from   = sel_idx;
        mv.move_to     = sel_to;
        mv.move_double = ~sel_single;
        mv.move_promo  = sel_single & sel_far;
        busy           = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign move_count = count_q;

endmodule
